// File: rtl/ir_pkg.sv
// Shared NEC IR transmitter definitions: FSM states, unit counts, frame helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } ir_state_t;

    // NEC timing, in units of 562.5 us
    localparam int LEAD_MARK_UNITS  = 16;
    localparam int LEAD_SPACE_UNITS = 8;
    localparam int BIT_MARK_UNITS   = 1;
    localparam int BIT_ONE_UNITS    = 3;
    localparam int BIT_ZERO_UNITS   = 1;
    localparam int STOP_MARK_UNITS  = 1;
    localparam int FRAME_UNITS      = 121;
    localparam int NEC_BITS         = 32;

    // Marks are the only states in which the LED is driven
    function automatic logic is_mark(input ir_state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

    // Frame word as sent LSB first: addr, ~addr, cmd, ~cmd
    function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

endpackage

// File: rtl/ir_carrier.sv
// Mark waveform generator: ~38 kHz square wave (or constant high) while en is set.
// Latency: car follows en/restart by one cycle; first cycle after restart is high.
// Backpressure: none; free-running whenever enabled.
module ir_carrier #(
    parameter int CAR_HALF = 658,
    parameter int MOD_EN   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic car
);

    localparam int HW = $clog2(CAR_HALF + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CAR_HALF - 1);

    logic [HW-1:0] r_cnt;
    logic          r_car;

    // Phase counter: restart forces a fresh high half-period, en=0 parks the output low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_car <= 1'b0;
        end else if (!en) begin
            r_cnt <= '0;
            r_car <= 1'b0;
        end else if (restart) begin
            r_cnt <= '0;
            r_car <= 1'b1;
        end else if (MOD_EN != 0) begin
            if (r_cnt == HALF_LAST) begin
                r_cnt <= '0;
                r_car <= ~r_car;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign car = r_car;

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR frame transmitter: lead, 32 pulse-distance bits LSB first, stop mark.
// Latency: busy rises the cycle after start; done pulses 121*UNIT_CYC cycles later.
// Backpressure: start is ignored while busy; a start in the done cycle chains frames.
module ir_nec_tx
    import ir_pkg::*;
#(
    parameter int UNIT_CYC   = 28125,
    parameter int CAR_HALF   = 658,
    parameter int CARRIER_EN = 1
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       IRDA_TXD,
    output logic       busy,
    output logic       done
);

    // Unit counter must hold the longest state (lead mark) in cycles
    localparam int CW = $clog2(UNIT_CYC * LEAD_MARK_UNITS);

    localparam logic [CW-1:0] LEAD_MARK_LAST  = CW'(LEAD_MARK_UNITS  * UNIT_CYC - 1);
    localparam logic [CW-1:0] LEAD_SPACE_LAST = CW'(LEAD_SPACE_UNITS * UNIT_CYC - 1);
    localparam logic [CW-1:0] BIT_MARK_LAST   = CW'(BIT_MARK_UNITS   * UNIT_CYC - 1);
    localparam logic [CW-1:0] BIT_ONE_LAST    = CW'(BIT_ONE_UNITS    * UNIT_CYC - 1);
    localparam logic [CW-1:0] BIT_ZERO_LAST   = CW'(BIT_ZERO_UNITS   * UNIT_CYC - 1);
    localparam logic [CW-1:0] STOP_MARK_LAST  = CW'(STOP_MARK_UNITS  * UNIT_CYC - 1);
    localparam logic [5:0]    LAST_BIT        = 6'(NEC_BITS - 1);

    ir_state_t     r_state;
    ir_state_t     w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [CW-1:0] w_space_last;
    logic [31:0]   r_shift;
    logic [31:0]   w_shift_nx;
    logic [5:0]    r_bit;
    logic [5:0]    w_bit_nx;
    logic          r_done;
    logic          w_done_nx;
    logic          w_mark_nx;
    logic          w_car_restart;

    // State, unit counter, shift register and done pulse registers
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_bit   <= w_bit_nx;
            r_done  <= w_done_nx;
        end
    end

    // Next-state logic: each state lasts a fixed number of units, counter wraps on every change
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt + 1'b1;
        w_shift_nx   = r_shift;
        w_bit_nx     = r_bit;
        w_done_nx    = 1'b0;
        w_space_last = r_shift[0] ? BIT_ONE_LAST : BIT_ZERO_LAST;
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (start) begin
                    w_state_nx = LEAD_MARK;
                    w_shift_nx = nec_word(addr, cmd);
                    w_bit_nx   = '0;
                end
            end
            LEAD_MARK: begin
                if (r_cnt == LEAD_MARK_LAST) begin
                    w_state_nx = LEAD_SPACE;
                    w_cnt_nx   = '0;
                end
            end
            LEAD_SPACE: begin
                if (r_cnt == LEAD_SPACE_LAST) begin
                    w_state_nx = BIT_MARK;
                    w_cnt_nx   = '0;
                end
            end
            BIT_MARK: begin
                if (r_cnt == BIT_MARK_LAST) begin
                    w_state_nx = BIT_SPACE;
                    w_cnt_nx   = '0;
                end
            end
            BIT_SPACE: begin
                if (r_cnt == w_space_last) begin
                    w_cnt_nx   = '0;
                    w_shift_nx = {1'b0, r_shift[31:1]};
                    w_bit_nx   = r_bit + 1'b1;
                    w_state_nx = (r_bit == LAST_BIT) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK: begin
                if (r_cnt == STOP_MARK_LAST) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    w_done_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Carrier is steered one cycle ahead so its registered output lines up with the state
    assign w_mark_nx     = is_mark(w_state_nx);
    assign w_car_restart = w_mark_nx & ~is_mark(r_state);

    ir_carrier #(
        .CAR_HALF (CAR_HALF),
        .MOD_EN   (CARRIER_EN)
    ) u_carrier (
        .clk     (CLOCK_50),
        .rst     (rst),
        .en      (w_mark_nx),
        .restart (w_car_restart),
        .car     (IRDA_TXD)
    );

    assign busy = (r_state != IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: two instances (plain and modulated mark) against a segment-list model.
// Latency: model predicts every output cycle from the frame's mark/space segment list.
// Backpressure: start pulses during a frame are expected to be ignored.
module tb_ir_nec_tx;

    localparam int U  = 10;
    localparam int CH = 2;

    logic       CLOCK_50;
    logic       rst;
    logic       start;
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       txd0, busy0, done0;
    logic       txd1, busy1, done1;

    int errors = 0;
    int checks = 0;

    ir_nec_tx #(.UNIT_CYC(U), .CAR_HALF(CH), .CARRIER_EN(0)) u_dut0 (
        .CLOCK_50 (CLOCK_50), .rst (rst), .start (start), .addr (addr), .cmd (cmd),
        .IRDA_TXD (txd0), .busy (busy0), .done (done0)
    );

    ir_nec_tx #(.UNIT_CYC(U), .CAR_HALF(CH), .CARRIER_EN(1)) u_dut1 (
        .CLOCK_50 (CLOCK_50), .rst (rst), .start (start), .addr (addr), .cmd (cmd),
        .IRDA_TXD (txd1), .busy (busy1), .done (done1)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit mark;
        int off;
    } ent_t;

    ent_t mq[$];

    function automatic void push_seg(input bit mark, input int units);
        for (int i = 0; i < units * U; i++) begin
            ent_t e;
            e.mark = mark;
            e.off  = i;
            mq.push_back(e);
        end
    endfunction

    function automatic void push_frame(input logic [31:0] w);
        push_seg(1'b1, 16);
        push_seg(1'b0, 8);
        for (int i = 0; i < 32; i++) begin
            push_seg(1'b1, 1);
            push_seg(1'b0, w[i] ? 3 : 1);
        end
        push_seg(1'b1, 1);
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    ent_t cur;
    bit   cur_busy = 1'b0;
    bit   was_busy;
    bit   e_done, e_t0, e_t1;

    // Compare process: advance the model at each edge, then check both DUTs just after it
    always @(posedge CLOCK_50) begin
        if (rst) begin
            mq.delete();
            cur_busy = 1'b0;
            e_done   = 1'b0;
            e_t0     = 1'b0;
            e_t1     = 1'b0;
        end else begin
            was_busy = cur_busy;
            if (!was_busy && start) push_frame(exp_word(addr, cmd));
            if (mq.size() > 0) begin
                cur      = mq.pop_front();
                cur_busy = 1'b1;
            end else begin
                cur_busy = 1'b0;
            end
            e_done = was_busy && !cur_busy;
            e_t0   = cur_busy && cur.mark;
            e_t1   = e_t0 && (((cur.off / CH) % 2) == 0);
        end
        #1;
        chk("busy0", 64'(busy0), 64'(cur_busy));
        chk("busy1", 64'(busy1), 64'(cur_busy));
        chk("done0", 64'(done0), 64'(e_done));
        chk("done1", 64'(done1), 64'(e_done));
        chk("txd_plain", 64'(txd0), 64'(e_t0));
        chk("txd_carrier", 64'(txd1), 64'(e_t1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic [7:0] a, input logic [7:0] c);
        addr  = a;
        cmd   = c;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    // Record the plain-mark waveform while busy and decode it into run lengths and bits
    task automatic capture(input int restart_at, input logic [7:0] na, input logic [7:0] nc,
                           output int len, output logic [31:0] w, output int lh,
                           output int ll, output int sh, output int nr, output logic [7:0] c8);
        int runs[$];
        bit prev;
        int rl;
        len  = 0;
        prev = 1'b1;
        rl   = 0;
        c8   = '0;
        while (busy0 && len < 3000) begin
            if (len == restart_at) begin
                start = 1'b1;
                addr  = na;
                cmd   = nc;
            end else begin
                start = 1'b0;
            end
            if (txd0 == prev) rl++;
            else begin
                runs.push_back(rl);
                prev = txd0;
                rl   = 1;
            end
            if (len < 8) c8 = {c8[6:0], txd1};
            len++;
            @(negedge CLOCK_50);
        end
        start = 1'b0;
        runs.push_back(rl);
        nr = runs.size();
        w  = '0;
        lh = 0;
        ll = 0;
        sh = 0;
        if (nr == 67) begin
            lh = runs[0];
            ll = runs[1];
            for (int i = 0; i < 32; i++) w[i] = (runs[3 + 2 * i] > 2 * U);
            sh = runs[66];
        end
    endtask

    int          len, lh, ll, sh, nr, len_a, len_b, marks, lead;
    logic [31:0] w;
    logic [7:0]  c8, a, c;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        addr  = '0;
        cmd   = '0;

        // Pin the model itself with hand-computed figures
        push_frame(32'h5AA5FF00);
        chk("model_len", 64'(mq.size()), 64'd1210);
        marks = 0;
        lead  = 0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].mark) marks++;
            if (mq[i].mark && lead == i) lead++;
        end
        chk("model_lead", 64'(lead), 64'd160);
        chk("model_marks", 64'(marks), 64'd490);
        mq.delete();

        repeat (3) @(negedge CLOCK_50);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_txd0", 64'(txd0), 64'd0);
        chk("rst_txd1", 64'(txd1), 64'd0);
        rst = 1'b0;
        @(negedge CLOCK_50);

        // Directed frame with fixed expectations
        pulse(8'h00, 8'hA5);
        capture(-1, 8'h00, 8'h00, len, w, lh, ll, sh, nr, c8);
        chk("t1_len", 64'(len), 64'd1210);
        chk("t1_runs", 64'(nr), 64'd67);
        chk("t1_lead_hi", 64'(lh), 64'd160);
        chk("t1_lead_lo", 64'(ll), 64'd80);
        chk("t1_bits", 64'(w), 64'h5AA5FF00);
        chk("t1_stop_hi", 64'(sh), 64'd10);
        chk("t1_done", 64'(done0), 64'd1);
        chk("t1_carrier", 64'(c8), 64'hCC);

        // Random frames with random idle gaps
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 20)) @(negedge CLOCK_50);
            a = 8'($urandom);
            c = 8'($urandom);
            pulse(a, c);
            capture(-1, 8'h00, 8'h00, len, w, lh, ll, sh, nr, c8);
            chk("rnd_len", 64'(len), 64'd1210);
            chk("rnd_bits", 64'(w), 64'(exp_word(a, c)));
            chk("rnd_carrier", 64'(c8), 64'hCC);
        end

        // Start re-pulsed mid-frame with different data must be ignored
        @(negedge CLOCK_50);
        a = 8'($urandom);
        c = 8'($urandom);
        pulse(a, c);
        capture(500, ~a, c ^ 8'h3C, len, w, lh, ll, sh, nr, c8);
        chk("mid_len", 64'(len), 64'd1210);
        chk("mid_bits", 64'(w), 64'(exp_word(a, c)));

        // Reset inside the first bit's space aborts at once with no done
        @(negedge CLOCK_50);
        pulse(8'($urandom), 8'($urandom));
        repeat (255) @(negedge CLOCK_50);
        rst = 1'b1;
        #1;
        chk("abort_busy0", 64'(busy0), 64'd0);
        chk("abort_busy1", 64'(busy1), 64'd0);
        chk("abort_txd0", 64'(txd0), 64'd0);
        chk("abort_txd1", 64'(txd1), 64'd0);
        chk("abort_done", 64'(done0), 64'd0);
        repeat (3) @(negedge CLOCK_50);
        rst = 1'b0;
        @(negedge CLOCK_50);
        a = 8'($urandom);
        c = 8'($urandom);
        pulse(a, c);
        capture(-1, 8'h00, 8'h00, len, w, lh, ll, sh, nr, c8);
        chk("post_rst_len", 64'(len), 64'd1210);
        chk("post_rst_bits", 64'(w), 64'(exp_word(a, c)));

        // Back-to-back: start during the done cycle
        @(negedge CLOCK_50);
        pulse(8'h12, 8'h34);
        capture(-1, 8'h00, 8'h00, len, w, lh, ll, sh, nr, c8);
        chk("b2b_done1", 64'(done0), 64'd1);
        a = 8'($urandom);
        c = 8'($urandom);
        pulse(a, c);
        chk("b2b_nogap", 64'(busy0), 64'd1);
        capture(-1, 8'h00, 8'h00, len, w, lh, ll, sh, nr, c8);
        chk("b2b_len", 64'(len), 64'd1210);
        chk("b2b_bits", 64'(w), 64'(exp_word(a, c)));
        chk("b2b_done2", 64'(done0), 64'd1);

        // Frame length does not depend on data
        @(negedge CLOCK_50);
        pulse(8'hFF, 8'hFF);
        capture(-1, 8'h00, 8'h00, len_a, w, lh, ll, sh, nr, c8);
        chk("ff_bits", 64'(w), 64'h00FF00FF);
        @(negedge CLOCK_50);
        pulse(8'h00, 8'h00);
        capture(-1, 8'h00, 8'h00, len_b, w, lh, ll, sh, nr, c8);
        chk("zz_bits", 64'(w), 64'hFF00FF00);
        chk("ff_len", 64'(len_a), 64'd1210);
        chk("zz_len", 64'(len_b), 64'd1210);

        repeat (5) @(negedge CLOCK_50);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ir_nec_tx.md
IR_NEC_TX -- requirements
Module: ir_nec_tx

Interface
REQ-001 SHALL have parameter UNIT_CYC, default 28125, meaning CLOCK_50 cycles per NEC unit (562.5 us).
REQ-002 SHALL have parameter CAR_HALF, default 658, meaning cycles per carrier half-period (about 38 kHz).
REQ-003 SHALL have parameter CARRIER_EN, default 1, meaning 1 = modulated mark and 0 = constant-high mark.
REQ-004 SHALL have one clock and an asynchronous active-high reset, listed first: CLOCK_50 input 1 (system clock); rst input 1 (reset).
REQ-005 SHALL have port start, input, 1 bit: one-cycle frame request.
REQ-006 SHALL have port addr, input, 8 bits: NEC address.
REQ-007 SHALL have port cmd, input, 8 bits: NEC command.
REQ-008 SHALL have port IRDA_TXD, output, 1 bit: IR LED drive, registered.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-011 SHALL implement states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE and STOP_MARK.
REQ-012 SHALL, in IDLE with start=1, latch frame word {~cmd, cmd, ~addr, addr} and enter LEAD_MARK on the next edge.
REQ-013 SHALL ignore start while busy=1; the latched data is unaffected by input changes mid-frame.
REQ-014 SHALL set durations as follows: LEAD_MARK 16 units, LEAD_SPACE 8 units, BIT_MARK 1 unit, BIT_SPACE 1 unit for a 0 bit and 3 units for a 1 bit, STOP_MARK 1 unit.
REQ-015 SHALL transmit 32 bits LSB first (addr bit0 first) using a 6-bit bit counter; after bit 31's space, enter STOP_MARK.
REQ-016 SHALL make total frame length always 121 units (121*UNIT_CYC cycles), independent of data.
REQ-017 SHALL hold IRDA_TXD at 0 during spaces and IDLE.
REQ-018 SHALL, during marks with CARRIER_EN=1, make IRDA_TXD a square wave of period 2*CAR_HALF.
REQ-019 SHALL restart the carrier phase at every mark start, so the first mark cycle is high and that high phase lasts CAR_HALF cycles.
REQ-020 SHALL, during marks with CARRIER_EN=0, hold IRDA_TXD at 1.
REQ-021 SHALL raise busy in the cycle after start is accepted and hold it through the last STOP_MARK cycle.
REQ-022 SHALL assert done for exactly one cycle on return to IDLE, in the same cycle busy falls.
REQ-023 SHALL accept start asserted in the same cycle done is high, with no gap: back-to-back frames.
REQ-024 SHALL size the unit counter to ceil(log2(UNIT_CYC*16)) bits and wrap it to 0 at each state change.

Reset
REQ-025 SHALL, on rst=1 and asynchronously, set state to IDLE, IRDA_TXD=0, busy=0, done=0, and clear all counters and the shift register.
REQ-026 SHALL, on reset mid-frame, abort the frame immediately with no done pulse; the first start after rst falls begins a fresh frame.

Structure
REQ-027 SHALL place the state enum and the NEC unit counts (16, 8, 1, 3, 1, 121) in shared package ir_pkg.
REQ-028 SHALL implement the carrier in sub-module ir_carrier (inputs en and restart, output car), instantiated once.

Verification (UNIT_CYC=10, CAR_HALF=2)
REQ-029 SHALL cover: addr=0x00, cmd=0xA5, CARRIER_EN=0 -> lead high for 160 cycles and low for 80; decoded bits 0x5AA5FF00; stop high for 10; done at cycle 1210 after busy rises.
REQ-030 SHALL cover: CARRIER_EN=1, any data -> each mark shows a 1,1,0,0 repeating pattern starting high; spaces are constant 0.
REQ-031 SHALL cover: start pulsed again at cycle 500 of a frame with new addr and cmd -> ignored; the frame finishes with the original data.
REQ-032 SHALL cover: rst asserted during a BIT_SPACE -> IRDA_TXD=0 and busy=0 immediately, no done; a new start yields a correct full frame.
REQ-033 SHALL cover: start held high during the done cycle -> a second frame begins with no IDLE gap; the second done arrives 1210 cycles later.
REQ-034 SHALL cover: addr=0xFF, cmd=0xFF versus addr=0x00, cmd=0x00 -> identical frame length of 1210 cycles.
